// File: rtl/serializer_pkg.sv
// serializer_pkg
// Shared types and helpers for the serial link blocks (serializer_v3 and the
// planned deserializer).
//   ser_state_t : frame FSM states (IDLE, SHIFT, DONE)
//   cnt_width() : counter width for a down-counter that starts at n-1,
//                 never narrower than one bit.
package serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_t;

  // $clog2(n) with a floor of 1, so n = 1 still yields a usable register.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serializer_v3_bit_rate_divider.sv
// bit_rate_divider
// Bit-period timer for the serializer. A Load starts a period of ClkDiv
// cycles; Tick is high during the last cycle of that period. The timer then
// stops unless it is loaded again, so it never counts below zero.
// Ports:
//   Clk   : clock, rising edge
//   Clr_n : asynchronous active-low reset
//   Load  : start a new bit period (counter <= ClkDiv-1)
//   Abort : stop the timer; takes priority over Load
//   Tick  : last cycle of the current bit period
module bit_rate_divider
  import serializer_pkg::*;
#(
  parameter int ClkDiv = 4
) (
  input  logic Clk,
  input  logic Clr_n,
  input  logic Load,
  input  logic Abort,
  output logic Tick
);

  localparam int              DivW   = cnt_width(ClkDiv);
  localparam logic [DivW-1:0] Reload = DivW'(ClkDiv - 1);

  logic [DivW-1:0] cnt;
  logic            run;

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (Abort) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (Load) begin
      cnt <= Reload;
      run <= 1'b1;
    end else if (run) begin
      // Period over with no reload: park at zero instead of wrapping.
      if (cnt == '0) run <= 1'b0;
      else           cnt <= cnt - 1'b1;
    end
  end

  assign Tick = run & (cnt == '0);

endmodule

// File: rtl/serializer_v3.sv
// serializer_v3
// Parallel-to-serial converter. Takes one frame of NumWords x WordWidth bits
// on a valid/ready handshake and sends it one bit per ClkDiv clocks.
// Parameters:
//   WordWidth : bits per word
//   NumWords  : words per frame (TotalBits = WordWidth*NumWords)
//   ClkDiv    : clocks per serial bit, >= 1
//   MsbFirst  : 1 sends DataIn[TotalBits-1] first, 0 sends DataIn[0] first
// Ports:
//   Clk, Clr_n : clock (rising edge), asynchronous active-low reset
//   DataIn     : frame; word 0 is DataIn[TotalBits-1 -: WordWidth]
//   InValid    : frame on DataIn is valid
//   InReady    : block can accept a frame (registered)
//   Abort      : synchronous kill of the frame in progress
//   SerialOut  : serial data, idles at 0 (registered)
//   BitStrobe  : pulse in the first cycle of each bit (registered)
//   Busy       : frame in progress (registered)
//   Done       : pulse after the last bit has completed (registered)
module serializer_v3
  import serializer_pkg::*;
#(
  parameter int WordWidth = 8,
  parameter int NumWords  = 2,
  parameter int ClkDiv    = 4,
  parameter bit MsbFirst  = 1'b1
) (
  input  logic                            Clk,
  input  logic                            Clr_n,
  input  logic [WordWidth*NumWords-1:0]   DataIn,
  input  logic                            InValid,
  output logic                            InReady,
  input  logic                            Abort,
  output logic                            SerialOut,
  output logic                            BitStrobe,
  output logic                            Busy,
  output logic                            Done
);

  localparam int              TotalBits = WordWidth * NumWords;
  localparam int              BitW      = cnt_width(TotalBits);
  localparam logic [BitW-1:0] LastIdx   = BitW'(TotalBits - 1);

  if (ClkDiv < 1) begin : g_bad_div
    $error("serializer_v3: ClkDiv must be >= 1");
  end

  ser_state_t           state, state_nxt;
  logic [TotalBits-1:0] shreg, shreg_nxt, shreg_adv;
  logic [BitW-1:0]      bitcnt, bitcnt_nxt;
  logic                 ser_nxt, stb_nxt, busy_nxt, done_nxt, rdy_nxt;
  logic                 accept, advance, tick;

  // Bit that goes on the line for a given shift-register image.
  function automatic logic head_bit(input logic [TotalBits-1:0] v);
    return MsbFirst ? v[TotalBits-1] : v[0];
  endfunction

  // The outgoing bit always sits at the head end, so shifting moves the
  // next bit into place.
  assign shreg_adv = MsbFirst ? (shreg << 1) : (shreg >> 1);

  assign accept  = (state == IDLE) & InValid & InReady & ~Abort;
  assign advance = (state == SHIFT) & tick & (bitcnt != '0) & ~Abort;

  bit_rate_divider #(
    .ClkDiv (ClkDiv)
  ) u_div (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .Load  (accept | advance),
    .Abort (Abort),
    .Tick  (tick)
  );

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // and registered, so each bit appears in the cycle after the edge that
  // loads it.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    ser_nxt    = SerialOut;
    stb_nxt    = 1'b0;
    busy_nxt   = Busy;
    done_nxt   = 1'b0;
    rdy_nxt    = InReady;

    if (Abort && (state != IDLE)) begin
      state_nxt = IDLE;
      ser_nxt   = 1'b0;
      busy_nxt  = 1'b0;
      rdy_nxt   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          ser_nxt  = 1'b0;
          busy_nxt = 1'b0;
          rdy_nxt  = 1'b1;
          if (accept) begin
            state_nxt  = SHIFT;
            shreg_nxt  = DataIn;
            bitcnt_nxt = LastIdx;
            ser_nxt    = head_bit(DataIn);
            stb_nxt    = 1'b1;
            busy_nxt   = 1'b1;
            rdy_nxt    = 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bitcnt != '0) begin
              shreg_nxt  = shreg_adv;
              bitcnt_nxt = bitcnt - 1'b1;
              ser_nxt    = head_bit(shreg_adv);
              stb_nxt    = 1'b1;
            end else begin
              state_nxt = DONE;
              ser_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
              rdy_nxt   = 1'b0;
            end
          end
        end
        DONE: begin
          state_nxt = IDLE;
          ser_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          rdy_nxt   = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          ser_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          rdy_nxt   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      SerialOut <= 1'b0;
      BitStrobe <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      InReady   <= 1'b1;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bitcnt    <= bitcnt_nxt;
      SerialOut <= ser_nxt;
      BitStrobe <= stb_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      InReady   <= rdy_nxt;
    end
  end

endmodule
